// File: rtl/recep_pkg.sv
// Shared definitions for the receptor command parser: PS/2 scan codes,
// parser state encoding and the digit scan-code table.
package recep_pkg;

    // Command and control scan codes
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_RESET = 8'h2D;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_Y     = 8'h35;
    localparam logic [7:0] SC_N     = 8'h31;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Digit scan codes, digit 0 in the least significant byte
    localparam logic [79:0] DIGIT_TBL = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                         8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_CHSEL = 3'd2,
        ST_DIGIT = 3'd3,
        ST_HAZ   = 3'd4,
        ST_GAS   = 3'd5
    } state_t;

    // Scan code of decimal digit d (d in 0..9)
    function automatic logic [7:0] digit_code(input logic [3:0] d);
        return DIGIT_TBL[int'(d) * 8 +: 8];
    endfunction

endpackage

// File: rtl/recep_cmd_parser_if.sv
// Scan-code stream from the PS/2 receiver into the command parser.
interface recep_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_code;

    modport master (output rx_valid, output rx_code);
    modport slave  (input  rx_valid, input  rx_code);
endinterface

// File: rtl/recep_cmd_parser_digit_dec.sv
// Combinational decoder from PS/2 scan code to a BCD digit.
module ps2_digit_dec
    import recep_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_is_digit,
    output logic [3:0] o_bcd
);

    // Compare the code against each digit entry; at most one can match
    always_comb begin
        o_is_digit = 1'b0;
        o_bcd      = 4'd0;
        for (int i = 0; i < 10; i++) begin
            o_is_digit = o_is_digit | (i_code == digit_code(4'(i)));
            o_bcd      = (i_code == digit_code(4'(i))) ? 4'(i) : o_bcd;
        end
    end

endmodule

// File: rtl/recep_cmd_parser.sv
// PS/2 command parser: interprets typed sequences that set channel
// temperatures (BCD), hazard level flags and the gas flag, with a
// break-code skip and an inactivity timeout back to idle.
module recep_cmd_parser
    import recep_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int NDIG    = 2,
    parameter int TMO_CYC = 50_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    recep_cmd_parser_if.slave        rx,
    output logic [NCH*NDIG*4-1:0]    o_temp_bcd,
    output logic [NCH-1:0]           o_temp_upd,
    output logic                     o_alerta,
    output logic                     o_peligro,
    output logic                     o_gas,
    output logic                     o_greset,
    output logic                     o_err,
    output logic                     o_busy
);

    localparam int SW       = NDIG * 4;
    localparam int TW       = NCH * SW;
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DC_W     = $clog2(NDIG + 1);
    localparam int TMO_W    = $clog2(TMO_CYC);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(NDIG - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t            r_state;
    logic              r_skip;
    logic [CH_W-1:0]   r_ch;
    logic [DC_W-1:0]   r_dcnt;
    logic [SW-1:0]     r_shadow;
    logic [TW-1:0]     r_temp;
    logic [TMO_W-1:0]  r_tmo;
    logic [NCH-1:0]    r_upd;
    logic              r_alerta;
    logic              r_peligro;
    logic              r_gas;
    logic              r_greset;
    logic              r_err;

    logic              w_is_digit;
    logic [3:0]        w_bcd;
    logic              w_ch_ok;
    logic [SW+3:0]     w_shift;
    logic [SW-1:0]     w_shadow_nx;
    logic [7:0]        w_code;

    assign w_code = rx.rx_code;

    ps2_digit_dec u_dec (
        .i_code     (w_code),
        .o_is_digit (w_is_digit),
        .o_bcd      (w_bcd)
    );

    // New digit enters at the least significant end; oldest digit drops off
    always_comb begin
        w_shift     = {r_shadow, w_bcd};
        w_shadow_nx = w_shift[SW-1:0];
        w_ch_ok     = w_is_digit && (32'(w_bcd) < NCH);
    end

    // Parser state machine, timeout counter, committed values and flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_skip    <= 1'b0;
            r_ch      <= '0;
            r_dcnt    <= '0;
            r_shadow  <= '0;
            r_temp    <= '0;
            r_tmo     <= '0;
            r_upd     <= '0;
            r_alerta  <= 1'b0;
            r_peligro <= 1'b0;
            r_gas     <= 1'b0;
            r_greset  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_upd    <= '0;
            r_greset <= 1'b0;
            r_err    <= 1'b0;
            if (rx.rx_valid) begin
                r_tmo <= '0;
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else if (w_code == SC_BREAK) begin
                    r_skip <= 1'b1;
                end else if (w_code == SC_EXT) begin
                    r_skip <= 1'b0;
                end else if (w_code == SC_I) begin
                    r_state <= ST_ARMED;
                end else begin
                    case (r_state)
                        ST_ARMED: begin
                            case (w_code)
                                SC_ENTER: r_state <= ST_CHSEL;
                                SC_H:     r_state <= ST_HAZ;
                                SC_G:     r_state <= ST_GAS;
                                SC_RESET: begin
                                    r_greset  <= 1'b1;
                                    r_alerta  <= 1'b0;
                                    r_peligro <= 1'b0;
                                    r_gas     <= 1'b0;
                                    r_state   <= ST_IDLE;
                                end
                                default:  r_state <= ST_ARMED;
                            endcase
                        end
                        ST_CHSEL: begin
                            if (w_ch_ok) begin
                                r_ch     <= w_bcd[CH_W-1:0];
                                r_dcnt   <= '0;
                                r_shadow <= '0;
                                r_state  <= ST_DIGIT;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_DIGIT: begin
                            if (w_is_digit) begin
                                r_shadow <= w_shadow_nx;
                                if (r_dcnt == DC_LAST) begin
                                    r_temp[32'(r_ch) * SW +: SW] <= w_shadow_nx;
                                    r_upd   <= NCH'(1) << r_ch;
                                    r_dcnt  <= '0;
                                    r_state <= ST_ARMED;
                                end else begin
                                    r_dcnt <= r_dcnt + DC_W'(1);
                                end
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_HAZ: begin
                            case (w_code)
                                SC_A: begin
                                    r_alerta  <= 1'b1;
                                    r_peligro <= 1'b0;
                                    r_state   <= ST_ARMED;
                                end
                                SC_P: begin
                                    r_alerta  <= 1'b1;
                                    r_peligro <= 1'b1;
                                    r_state   <= ST_ARMED;
                                end
                                SC_Y, SC_N, SC_G, SC_ENTER: begin
                                    r_err   <= 1'b1;
                                    r_state <= ST_ARMED;
                                end
                                default: r_state <= ST_HAZ;
                            endcase
                        end
                        ST_GAS: begin
                            case (w_code)
                                SC_Y: begin
                                    r_gas   <= 1'b1;
                                    r_state <= ST_ARMED;
                                end
                                SC_N: begin
                                    r_gas   <= 1'b0;
                                    r_state <= ST_ARMED;
                                end
                                default: r_state <= ST_GAS;
                            endcase
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end else if (r_state != ST_IDLE) begin
                if (r_tmo == TMO_LAST) begin
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                    r_skip  <= 1'b0;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign o_temp_bcd = r_temp;
    assign o_temp_upd = r_upd;
    assign o_alerta   = r_alerta;
    assign o_peligro  = r_peligro;
    assign o_gas      = r_gas;
    assign o_greset   = r_greset;
    assign o_err      = r_err;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_recep_cmd_parser.sv
// Self-checking bench for recep_cmd_parser: directed sequences plus a
// randomized run against a sequence-level reference model.
module tb_recep_cmd_parser;

    localparam int NCH  = 2;
    localparam int NDIG = 2;
    localparam int TMO  = 10;
    localparam int TW   = NCH * NDIG * 4;
    localparam int SW   = NDIG * 4;

    localparam int MS_IDLE = 0, MS_ARMED = 1, MS_CHSEL = 2, MS_DIGIT = 3,
                   MS_HAZ = 4, MS_GAS = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [TW-1:0]  temp_bcd;
    logic [NCH-1:0] temp_upd;
    logic alerta, peligro, gas, greset, err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int             m_state;
    bit             m_skip;
    int             m_ch;
    int             m_dig[$];
    int             m_temp[NCH];
    bit             m_alerta, m_peligro, m_gas;
    int             m_idle;
    logic [NCH-1:0] e_upd;
    bit             e_greset, e_err;

    logic [7:0] dtab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    recep_cmd_parser_if rxif ();

    recep_cmd_parser #(.NCH(NCH), .NDIG(NDIG), .TMO_CYC(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .rx         (rxif),
        .o_temp_bcd (temp_bcd),
        .o_temp_upd (temp_upd),
        .o_alerta   (alerta),
        .o_peligro  (peligro),
        .o_gas      (gas),
        .o_greset   (greset),
        .o_err      (err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int dig_of(input logic [7:0] c);
        for (int i = 0; i < 10; i++) if (dtab[i] == c) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_state = MS_IDLE; m_skip = 0; m_ch = 0; m_dig.delete();
        for (int c = 0; c < NCH; c++) m_temp[c] = 0;
        m_alerta = 0; m_peligro = 0; m_gas = 0; m_idle = 0;
        e_upd = '0; e_greset = 0; e_err = 0;
    endfunction

    function automatic void model_update(input bit v, input logic [7:0] c);
        int d;
        int val;
        d = dig_of(c);
        e_upd = '0; e_greset = 0; e_err = 0;
        if (v) begin
            m_idle = 0;
            if (m_skip) m_skip = 0;
            else if (c == 8'hF0) m_skip = 1;
            else if (c == 8'hE0) m_skip = 0;
            else if (c == 8'h43) m_state = MS_ARMED;
            else begin
                case (m_state)
                    MS_ARMED: begin
                        if (c == 8'h5A) m_state = MS_CHSEL;
                        else if (c == 8'h33) m_state = MS_HAZ;
                        else if (c == 8'h34) m_state = MS_GAS;
                        else if (c == 8'h2D) begin
                            e_greset = 1; m_alerta = 0; m_peligro = 0; m_gas = 0;
                            m_state = MS_IDLE;
                        end
                    end
                    MS_CHSEL: begin
                        if (d >= 0 && d < NCH) begin
                            m_ch = d; m_dig.delete(); m_state = MS_DIGIT;
                        end else begin
                            e_err = 1; m_state = MS_IDLE;
                        end
                    end
                    MS_DIGIT: begin
                        if (d >= 0) begin
                            m_dig.push_back(d);
                            if (m_dig.size() == NDIG) begin
                                val = 0;
                                foreach (m_dig[k]) val = val * 16 + m_dig[k];
                                m_temp[m_ch] = val;
                                e_upd[m_ch] = 1'b1;
                                m_dig.delete();
                                m_state = MS_ARMED;
                            end
                        end else begin
                            e_err = 1; m_state = MS_IDLE;
                        end
                    end
                    MS_HAZ: begin
                        if (c == 8'h1C) begin m_alerta = 1; m_peligro = 0; m_state = MS_ARMED; end
                        else if (c == 8'h4D) begin m_alerta = 1; m_peligro = 1; m_state = MS_ARMED; end
                        else if (c == 8'h35 || c == 8'h31 || c == 8'h34 || c == 8'h5A) begin
                            e_err = 1; m_state = MS_ARMED;
                        end
                    end
                    MS_GAS: begin
                        if (c == 8'h35) begin m_gas = 1; m_state = MS_ARMED; end
                        else if (c == 8'h31) begin m_gas = 0; m_state = MS_ARMED; end
                    end
                    default: m_state = MS_IDLE;
                endcase
            end
        end else if (m_state != MS_IDLE) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_err = 1; m_state = MS_IDLE; m_skip = 0; m_idle = 0;
            end
        end
    endfunction

    function automatic logic [TW-1:0] exp_temp();
        logic [TW-1:0] t;
        t = '0;
        for (int c = 0; c < NCH; c++) t[c*SW +: SW] = SW'(m_temp[c]);
        return t;
    endfunction

    function automatic logic [TW+NCH+5:0] exp_all();
        return {exp_temp(), e_upd, m_alerta, m_peligro, m_gas, e_greset, e_err,
                (m_state != MS_IDLE)};
    endfunction

    // One clock cycle of stimulus; the model advances with the DUT edge
    task automatic step(input bit r, input bit v, input logic [7:0] c);
        rst = r; rxif.rx_valid = v; rxif.rx_code = c;
        @(posedge clk);
        if (r) model_reset(); else model_update(v, c);
        #1;
        rst = 1'b0; rxif.rx_valid = 1'b0; rxif.rx_code = 8'h00;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b0, 1'b1, c);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        n_tests++; if (temp_bcd !== '0) begin n_fail++; $display("FAIL rst_temp got %h exp 0", temp_bcd); end
        n_tests++; if (temp_upd !== '0) begin n_fail++; $display("FAIL rst_upd got %b exp 0", temp_upd); end
        n_tests++; if ({alerta, peligro, gas} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {alerta, peligro, gas}); end
        n_tests++; if ({greset, err, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b exp 000", {greset, err, busy}); end
    endtask

    task automatic test_temp_entry();
        send(8'h43); send(8'h5A); send(8'h16); send(8'h26);
        n_tests++; if (temp_upd !== 2'b00) begin n_fail++; $display("FAIL temp_early_upd got %b exp 00", temp_upd); end
        send(8'h3D);
        n_tests++; if (temp_upd !== 2'b10) begin n_fail++; $display("FAIL temp_upd got %b exp 10", temp_upd); end
        n_tests++; if (temp_bcd !== 16'h3700) begin n_fail++; $display("FAIL temp_val got %h exp 3700", temp_bcd); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL temp_busy got %b exp 1", busy); end
        step(1'b0, 1'b0, 8'h00);
        n_tests++; if (temp_upd !== 2'b00) begin n_fail++; $display("FAIL temp_upd_pulse got %b exp 00", temp_upd); end
    endtask

    task automatic test_break_skip();
        send(8'h43); send(8'h5A); send(8'h45); send(8'h1E);
        send(8'hF0); send(8'h1E); send(8'hE0); send(8'h2E);
        n_tests++; if (temp_bcd !== 16'h3725) begin n_fail++; $display("FAIL skip_val got %h exp 3725", temp_bcd); end
        n_tests++; if (temp_upd !== 2'b01) begin n_fail++; $display("FAIL skip_upd got %b exp 01", temp_upd); end
    endtask

    task automatic test_error_haz();
        send(8'h43); send(8'h5A); send(8'h45); send(8'h1E); send(8'h33);
        n_tests++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL digerr got err,busy=%b exp 10", {err, busy}); end
        n_tests++; if (temp_bcd !== 16'h3725) begin n_fail++; $display("FAIL digerr_keep got %h exp 3725", temp_bcd); end
        send(8'h43); send(8'h33); send(8'h4D);
        n_tests++; if ({alerta, peligro, err} !== 3'b110) begin n_fail++; $display("FAIL haz_p got %b exp 110", {alerta, peligro, err}); end
        send(8'h33); send(8'h35);
        n_tests++; if ({alerta, peligro, err, busy} !== 4'b1111) begin n_fail++; $display("FAIL haz_err got %b exp 1111", {alerta, peligro, err, busy}); end
    endtask

    task automatic test_gas_reset();
        send(8'h43); send(8'h34); send(8'h35);
        n_tests++; if (gas !== 1'b1) begin n_fail++; $display("FAIL gas_set got %b exp 1", gas); end
        send(8'h43); send(8'h2D);
        n_tests++; if ({greset, alerta, peligro, gas, busy} !== 5'b10000) begin n_fail++; $display("FAIL greset got %b exp 10000", {greset, alerta, peligro, gas, busy}); end
        step(1'b0, 1'b0, 8'h00);
        n_tests++; if (greset !== 1'b0) begin n_fail++; $display("FAIL greset_pulse got %b exp 0", greset); end
    endtask

    task automatic test_timeout();
        send(8'h43); send(8'h5A);
        for (int i = 1; i < TMO; i++) step(1'b0, 1'b0, 8'h00);
        n_tests++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early got %b exp 01", {err, busy}); end
        step(1'b0, 1'b0, 8'h00);
        n_tests++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL tmo_expire got %b exp 10", {err, busy}); end
        send(8'h43); send(8'h5A);
        for (int i = 1; i < TMO; i++) step(1'b0, 1'b0, 8'h00);
        send(8'h16);
        n_tests++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_rescue got %b exp 01", {err, busy}); end
    endtask

    task automatic test_rst_mid();
        send(8'h43); send(8'h5A); send(8'h45); send(8'h16);
        step(1'b1, 1'b1, 8'h1E);
        n_tests++; if ({temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy} !== '0) begin
            n_fail++; $display("FAIL rst_mid got %h exp 0", {temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy});
        end
    endtask

    function automatic logic [7:0] pick_code();
        case ($urandom_range(0, 15))
            0, 1:          return 8'h43;
            2:             return 8'h5A;
            3, 4, 5, 6, 7: return dtab[$urandom_range(0, 9)];
            8:             return 8'h33;
            9:             return ($urandom_range(0, 1) != 0) ? 8'h1C : 8'h4D;
            10:            return 8'h34;
            11:            return ($urandom_range(0, 1) != 0) ? 8'h35 : 8'h31;
            12:            return 8'hF0;
            13:            return 8'hE0;
            14:            return 8'h2D;
            default:       return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_random();
        int gap;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) step(1'b1, $urandom_range(0, 1) != 0, pick_code());
            else if ($urandom_range(0, 7) == 0) begin
                gap = $urandom_range(1, 14);
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 8'h00);
                    n_tests++;
                    if ({temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy} !== exp_all()) begin
                        n_fail++; $display("FAIL rnd_idle n=%0d got %h exp %h", n,
                            {temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy}, exp_all());
                    end
                end
            end else send(pick_code());
            n_tests++;
            if ({temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy} !== exp_all()) begin
                n_fail++; $display("FAIL rnd n=%0d got %h exp %h", n,
                    {temp_bcd, temp_upd, alerta, peligro, gas, greset, err, busy}, exp_all());
            end
        end
    endtask

    initial begin
        rxif.rx_valid = 1'b0;
        rxif.rx_code  = 8'h00;
        model_reset();
        test_reset();
        test_temp_entry();
        test_break_skip();
        test_error_haz();
        test_gas_reset();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recep_cmd_parser.md
RECEP_CMD_PARSER -- requirements
Module: recep_cmd_parser

Interface
REQ-001 NCH, default 2: number of temperature channels, 1..9.
REQ-002 NDIG, default 2: BCD digits per temperature value, 1..4.
REQ-003 TMO_CYC, default 50_000_000: inactivity timeout in CLK cycles, >=2.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_code is valid while it is high.
REQ-007 rx_code  in  8  PS/2 scan code.
REQ-008 temp_bcd  out  NCH*NDIG*4  committed values; channel c at bits [(c+1)*NDIG*4-1 : c*NDIG*4]; most significant digit first.
REQ-009 temp_upd  out  NCH  one-cycle pulse per channel on commit.
REQ-010 alerta, peligro, gas  out  1 each  level status flags.
REQ-011 greset  out  1  one-cycle pulse on the Reset command.
REQ-012 err  out  1  one-cycle pulse on protocol error or timeout.
REQ-013 busy  out  1  high whenever state != IDLE.

Function
REQ-014 Scan codes: I=43, Enter=5A, Reset=2D, H=33, A=1C, P=4D, G=34, Y=35, N=31, break=F0, ext=E0; digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46 (hex).
REQ-015 Code F0 sets skip; the next rx_valid code is discarded and skip cleared; neither code affects state.
REQ-016 Code E0 is discarded and does not change skip or state.
REQ-017 States: IDLE, ARMED, CHSEL, DIGIT, HAZ, GAS.
REQ-018 Accepted I in any state -> ARMED, abandoning any partial entry without err.
REQ-019 IDLE: non-I codes ignored.
REQ-020 ARMED: Enter->CHSEL; H->HAZ; G->GAS; Reset->greset pulse, clear alerta/peligro/gas, ->IDLE; other codes ignored.
REQ-021 CHSEL: digit d < NCH latches channel d, clears digit count, ->DIGIT; any other code -> err, ->IDLE.
REQ-022 DIGIT: digit is shifted into the shadow register; after the NDIG-th digit, shadow is copied to the selected channel slice, temp_upd[ch] pulses, ->ARMED.
REQ-023 DIGIT: non-digit -> err, ->IDLE; the committed value is unchanged (no partial commit).
REQ-024 HAZ: A->alerta=1, peligro=0; P->alerta=1, peligro=1; Y, N, G or Enter -> err; all ->ARMED; other codes ignored.
REQ-025 GAS: Y->gas=1; N->gas=0; both ->ARMED; other codes ignored.
REQ-026 Output latency: one cycle; pulses and register updates are visible the cycle after the accepted rx_valid.
REQ-027 Timeout counter: reloads on every rx_valid, including F0 and E0.
REQ-028 Timeout: in any state other than IDLE, TMO_CYC cycles without rx_valid -> err pulse, ->IDLE, skip cleared.
REQ-029 rx_valid coinciding with timeout expiry: the code is processed and no timeout occurs.
REQ-030 Digit counter width is clog2(NDIG+1); the counter never wraps past NDIG.

Reset
REQ-031 RST has priority over rx_valid and timeout.
REQ-032 RST results: state=IDLE, skip=0, counters=0, temp_bcd all zero, and all outputs 0.
REQ-033 RST mid-entry discards the shadow register without commit or err.

Structure
REQ-034 Shared package recep_pkg holds the scan code constants, the state encoding and the digit code table.
REQ-035 Sub-module ps2_digit_dec: combinational, rx_code -> {is_digit, bcd[3:0]}; it is the only decoder of digit codes.

Verification
REQ-036 NCH=2, NDIG=2: 43,5A,16,26,3D -> temp_upd=2'b10, channel 1 = 8'h37, channel 0 = 00.
REQ-037 43,5A,45,1E,F0,1E,2E -> channel 0 = 8'h25; the released 1E is skipped.
REQ-038 43,5A,45,1E,33 -> err pulse, IDLE, channel 0 unchanged; then 43,33,4D -> alerta=1, peligro=1.
REQ-039 43,34,35 -> gas=1; 43,2D -> greset one cycle, alerta/peligro/gas=0, busy=0.
REQ-040 TMO_CYC=10: 43,5A, then idle 10 cycles -> err at cycle 10, busy=0; a code exactly at expiry -> no err.
REQ-041 RST asserted with rx_valid mid-DIGIT -> all outputs 0 next cycle, no temp_upd, no err.
